// File: rtl/apb_master_if.sv
// Bundle of the local command/response port and the APB requester-side bus,
// seen from the bridge (master) or from the surrounding logic (slave).
interface apb_master_if #(
  parameter int ADDWIDTH  = 8,
  parameter int DATAWIDTH = 32
);
  localparam int STRBWIDTH = DATAWIDTH / 8;

  // Local command port
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_write;
  logic [ADDWIDTH-1:0]  cmd_addr;
  logic [DATAWIDTH-1:0] cmd_wdata;
  logic [STRBWIDTH-1:0] cmd_strb;

  // Local response port
  logic                 rsp_valid;
  logic [DATAWIDTH-1:0] rsp_rdata;
  logic                 rsp_err;

  // APB bus
  logic                 PSEL;
  logic                 PENABLE;
  logic                 PWRITE;
  logic [ADDWIDTH-1:0]  PADDR;
  logic [DATAWIDTH-1:0] PWDATA;
  logic [STRBWIDTH-1:0] PSTRB;
  logic                 PREADY;
  logic [DATAWIDTH-1:0] PRDATA;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PREADY, PRDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PREADY, PRDATA
  );
endinterface

// File: rtl/apb_master.sv
// APB requester: one command at a time, SETUP/ACCESS transfer with bounded PREADY
// wait, one-cycle response pulse. Every output comes straight from a register.
module apb_master #(
  parameter int ADDWIDTH  = 8,
  parameter int DATAWIDTH = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic            PCLK,
  input  logic            PRESET,
  apb_master_if.master    bus
);

  localparam int STRBWIDTH = DATAWIDTH / 8;
  localparam int CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LIMIT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_e;

  state_e               state_q,     state_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DATAWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q,   rsp_err_d;
  logic                 psel_q,      psel_d;
  logic                 penable_q,   penable_d;
  logic                 pwrite_q,    pwrite_d;
  logic [ADDWIDTH-1:0]  paddr_q,     paddr_d;
  logic [DATAWIDTH-1:0] pwdata_q,    pwdata_d;
  logic [STRBWIDTH-1:0] pstrb_q,     pstrb_d;
  logic [CNT_W-1:0]     wait_cnt_q,  wait_cnt_d;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    wait_cnt_d  = wait_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          state_d     = S_SETUP;
          cmd_ready_d = 1'b0;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          pwrite_d    = bus.cmd_write;
          paddr_d     = bus.cmd_addr;
          // Reads put nothing on the write lanes.
          pwdata_d    = bus.cmd_write ? bus.cmd_wdata : '0;
          pstrb_d     = bus.cmd_write ? bus.cmd_strb  : '0;
        end
      end

      S_SETUP: begin
        state_d    = S_ACCESS;
        penable_d  = 1'b1;
        wait_cnt_d = '0;
      end

      S_ACCESS: begin
        // PREADY wins over the timeout when both land in the same cycle.
        if (bus.PREADY) begin
          state_d     = S_IDLE;
          cmd_ready_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
        end else if ((TIMEOUT != 0) && (wait_cnt_q == WAIT_LIMIT)) begin
          state_d     = S_IDLE;
          cmd_ready_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else if (TIMEOUT != 0) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
      end
    endcase
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.PSTRB     = pstrb_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master (TIMEOUT=4): write, read, waited read, timeout,
// back-to-back commands and reset during ACCESS.
module tb_apb_master;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  apb_master_if #(.ADDWIDTH(8), .DATAWIDTH(32)) bus ();

  apb_master #(
    .ADDWIDTH (8),
    .DATAWIDTH(32),
    .TIMEOUT  (4)
  ) dut (
    .PCLK  (clk),
    .PRESET(rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_strb  = strb;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_strb  = '0;
    bus.PREADY    = 1'b0;
    bus.PRDATA    = '0;

    // Reset state
    step();
    step();
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_err",   bus.rsp_err,   0);
    chk("rst_psel",      bus.PSEL,      0);
    chk("rst_penable",   bus.PENABLE,   0);
    chk("rst_pwrite",    bus.PWRITE,    0);
    chk("rst_paddr",     bus.PADDR,     0);
    chk("rst_pwdata",    bus.PWDATA,    0);
    chk("rst_pstrb",     bus.PSTRB,     0);
    rst = 1'b0;
    step();
    $display("reset done");

    // 1: write with PREADY high
    send(1'b1, 8'h10, 32'hDEADBEEF, 4'hF);
    bus.PREADY = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    chk("t1_setup_psel",    bus.PSEL,      1);
    chk("t1_setup_penable", bus.PENABLE,   0);
    chk("t1_setup_pwrite",  bus.PWRITE,    1);
    chk("t1_setup_paddr",   bus.PADDR,     8'h10);
    chk("t1_setup_pwdata",  bus.PWDATA,    32'hDEADBEEF);
    chk("t1_setup_pstrb",   bus.PSTRB,     4'hF);
    chk("t1_setup_ready",   bus.cmd_ready, 0);
    step();
    chk("t1_access_psel",    bus.PSEL,    1);
    chk("t1_access_penable", bus.PENABLE, 1);
    chk("t1_access_paddr",   bus.PADDR,   8'h10);
    chk("t1_access_rspv",    bus.rsp_valid, 0);
    step();
    chk("t1_rsp_valid", bus.rsp_valid, 1);
    chk("t1_rsp_err",   bus.rsp_err,   0);
    chk("t1_rsp_rdata", bus.rsp_rdata, 0);
    chk("t1_idle_psel", bus.PSEL,      0);
    chk("t1_idle_ready", bus.cmd_ready, 1);
    chk("t1_hold_paddr", bus.PADDR,    8'h10);
    step();
    chk("t1_rsp_pulse_end", bus.rsp_valid, 0);
    $display("txn1 write addr=0x10 data=0xdeadbeef checks=%0d failures=%0d", checks, failures);

    // 2: read with PREADY high
    send(1'b0, 8'h20, 32'hFFFFFFFF, 4'hF);
    bus.PRDATA = 32'h12345678;
    step();
    bus.cmd_valid = 1'b0;
    chk("t2_setup_pwrite", bus.PWRITE, 0);
    chk("t2_setup_pstrb",  bus.PSTRB,  0);
    chk("t2_setup_pwdata", bus.PWDATA, 0);
    chk("t2_setup_paddr",  bus.PADDR,  8'h20);
    step();
    chk("t2_access_penable", bus.PENABLE, 1);
    step();
    chk("t2_rsp_valid", bus.rsp_valid, 1);
    chk("t2_rsp_rdata", bus.rsp_rdata, 32'h12345678);
    chk("t2_rsp_err",   bus.rsp_err,   0);
    step();
    $display("txn2 read addr=0x20 checks=%0d failures=%0d", checks, failures);

    // 3: read with three wait states; the last ACCESS cycle sits on the timeout limit
    send(1'b0, 8'h30, 32'h0, 4'h0);
    bus.PREADY = 1'b0;
    bus.PRDATA = 32'hCAFEF00D;
    step();
    bus.cmd_valid = 1'b0;
    chk("t3_setup_psel", bus.PSEL, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_wait_psel",    bus.PSEL,      1);
      chk("t3_wait_penable", bus.PENABLE,   1);
      chk("t3_wait_paddr",   bus.PADDR,     8'h30);
      chk("t3_wait_pwrite",  bus.PWRITE,    0);
      chk("t3_wait_rspv",    bus.rsp_valid, 0);
    end
    step();
    chk("t3_last_penable", bus.PENABLE, 1);
    chk("t3_last_paddr",   bus.PADDR,   8'h30);
    bus.PREADY = 1'b1;
    step();
    bus.PREADY = 1'b0;
    chk("t3_rsp_valid", bus.rsp_valid, 1);
    chk("t3_rsp_rdata", bus.rsp_rdata, 32'hCAFEF00D);
    chk("t3_rsp_err",   bus.rsp_err,   0);
    step();
    chk("t3_rsp_pulse_end", bus.rsp_valid, 0);
    $display("txn3 waited read addr=0x30 checks=%0d failures=%0d", checks, failures);

    // 4: timeout with PREADY stuck low
    send(1'b0, 8'h40, 32'h0, 4'h0);
    bus.PRDATA = 32'h55555555;
    step();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t4_wait_psel",    bus.PSEL,      1);
      chk("t4_wait_penable", bus.PENABLE,   1);
      chk("t4_wait_rspv",    bus.rsp_valid, 0);
    end
    step();
    chk("t4_abort_psel",    bus.PSEL,      0);
    chk("t4_abort_penable", bus.PENABLE,   0);
    chk("t4_abort_rspv",    bus.rsp_valid, 1);
    chk("t4_abort_err",     bus.rsp_err,   1);
    chk("t4_abort_rdata",   bus.rsp_rdata, 0);
    chk("t4_abort_ready",   bus.cmd_ready, 1);
    step();
    chk("t4_after_rspv", bus.rsp_valid, 0);
    chk("t4_after_err",  bus.rsp_err,   0);
    $display("txn4 timeout read addr=0x40 checks=%0d failures=%0d", checks, failures);

    // 5: back-to-back, cmd_valid held high across both commands
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'h0BADF00D;
    send(1'b1, 8'h50, 32'hA5A5A5A5, 4'h3);
    step();
    chk("t5a_setup_paddr", bus.PADDR,  8'h50);
    chk("t5a_setup_pstrb", bus.PSTRB,  4'h3);
    send(1'b0, 8'h60, 32'h0, 4'h0);
    step();
    chk("t5a_access_paddr",  bus.PADDR,  8'h50);
    chk("t5a_access_pwrite", bus.PWRITE, 1);
    step();
    chk("t5a_rsp_valid", bus.rsp_valid, 1);
    chk("t5a_rsp_ready", bus.cmd_ready, 1);
    step();
    bus.cmd_valid = 1'b0;
    chk("t5b_setup_psel",    bus.PSEL,      1);
    chk("t5b_setup_penable", bus.PENABLE,   0);
    chk("t5b_setup_paddr",   bus.PADDR,     8'h60);
    chk("t5b_setup_pwrite",  bus.PWRITE,    0);
    chk("t5b_setup_rspv",    bus.rsp_valid, 0);
    step();
    step();
    chk("t5b_rsp_valid", bus.rsp_valid, 1);
    chk("t5b_rsp_rdata", bus.rsp_rdata, 32'h0BADF00D);
    step();
    $display("txn5 back-to-back write 0x50 / read 0x60 checks=%0d failures=%0d", checks, failures);

    // 6: reset during ACCESS
    bus.PREADY = 1'b0;
    send(1'b0, 8'h70, 32'h0, 4'h0);
    step();
    bus.cmd_valid = 1'b0;
    step();
    chk("t6_access_penable", bus.PENABLE, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_psel",    bus.PSEL,      0);
    chk("t6_rst_penable", bus.PENABLE,   0);
    chk("t6_rst_rspv",    bus.rsp_valid, 0);
    chk("t6_rst_ready",   bus.cmd_ready, 1);
    chk("t6_rst_paddr",   bus.PADDR,     0);
    step();
    chk("t6_post_rspv", bus.rsp_valid, 0);
    chk("t6_post_psel", bus.PSEL,      0);
    $display("txn6 reset during access addr=0x70 checks=%0d failures=%0d", checks, failures);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
